// File: rtl/axis_pkt_fifo_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo_if
// AXI Stream bundle used on both sides of axis_pkt_fifo.
//   tvalid  beat valid                tdata  payload (DATA_WIDTH)
//   tkeep   byte enables (DATA/8)     tlast  last beat of packet
//   tuser   sideband, bit 0 = frame error
//   tready  sink accepts beat
// master: drives the stream, slave: receives it.
// -----------------------------------------------------------------------------
interface axis_pkt_fifo_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 1
);
    localparam int TKEEP_WIDTH = DATA_WIDTH / 8;

    logic                   tvalid;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tready;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
// Single-clock store-and-forward AXI Stream packet FIFO. A packet is only
// exposed downstream once its tlast beat has been accepted; errored, oversized
// or FIFO-overflowing packets are discarded whole.
//
// Ports:
//   axis_aclk   clock
//   axis_reset  synchronous reset, active high
//   s_axis      upstream stream (slave modport of axis_pkt_fifo_if)
//   m_axis      downstream stream (master modport of axis_pkt_fifo_if)
//   drop_pulse  one-cycle pulse per discarded packet
//   pkt_count   number of complete packets currently stored
//
// Build option: AXIS_PKT_FIFO_TUSER_DROP_EN
//   defined   - tuser[0] marks a frame error and drops the packet; tuser is not
//               stored and m_axis.tuser is driven to zero.
//   undefined - tuser is stored per beat and forwarded; only oversize and
//               overflow drops occur.
// -----------------------------------------------------------------------------
module axis_pkt_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 64,
    parameter int TUSER_WIDTH   = 1,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    axis_pkt_fifo_if.slave                s_axis,
    axis_pkt_fifo_if.master               m_axis,
    output logic                          drop_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   pkt_count
);
    localparam int TKEEP_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int BCNT_WIDTH  = $clog2(MAX_PKT_BEATS + 1);
`ifdef AXIS_PKT_FIFO_TUSER_DROP_EN
    localparam int ENTRY_WIDTH = DATA_WIDTH + TKEEP_WIDTH + 1;
`else
    localparam int ENTRY_WIDTH = DATA_WIDTH + TKEEP_WIDTH + 1 + TUSER_WIDTH;
`endif
    localparam logic [PTR_WIDTH:0]    DEPTH_OCC    = (PTR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0]    PTR_ONE      = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0]    CNT_ONE      = (PTR_WIDTH + 1)'(1);
    localparam logic [BCNT_WIDTH-1:0] BCNT_ONE     = BCNT_WIDTH'(1);
    localparam logic [BCNT_WIDTH-1:0] BCNT_ZERO    = BCNT_WIDTH'(0);
    // beat_cnt value before the accept that would make the packet oversize
    localparam logic [BCNT_WIDTH-1:0] BCNT_LIMIT   = BCNT_WIDTH'(MAX_PKT_BEATS - 1);

    typedef enum logic [0:0] {
        ST_RX   = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ENTRY_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH:0]      r_wr_ptr;
    logic [PTR_WIDTH:0]      r_commit_ptr;
    logic [PTR_WIDTH:0]      r_rd_ptr;
    logic [BCNT_WIDTH-1:0]   r_beat_cnt;
    logic                    r_err;
    logic                    r_drop_pulse;
    logic [PTR_WIDTH:0]      r_pkt_count;

    logic [PTR_WIDTH:0]      w_wr_ptr_nxt;
    logic [PTR_WIDTH:0]      w_commit_ptr_nxt;
    logic [BCNT_WIDTH-1:0]   w_beat_cnt_nxt;
    logic                    w_err_nxt;
    logic                    w_drop_nxt;
    logic                    w_commit;
    logic                    w_wr_en;
    logic                    w_tready;
    logic                    w_full;
    logic                    w_beat_err;
    logic [ENTRY_WIDTH-1:0]  w_wr_entry;
    logic [ENTRY_WIDTH-1:0]  w_rd_entry;
    logic                    w_m_valid;
    logic                    w_rd_fire;
    logic                    w_rd_last_fire;

    // Occupancy includes the speculative (uncommitted) tail of the packet.
    assign w_full = ((r_wr_ptr - r_rd_ptr) == DEPTH_OCC);

`ifdef AXIS_PKT_FIFO_TUSER_DROP_EN
    assign w_beat_err = s_axis.tuser[0];
    assign w_wr_entry = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
`else
    assign w_beat_err = 1'b0;
    assign w_wr_entry = {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
`endif

    // Next-state and write-side control for the RX/DROP machine
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_err_nxt        = r_err;
        w_drop_nxt       = 1'b0;
        w_commit         = 1'b0;
        w_wr_en          = 1'b0;
        w_tready         = 1'b0;
        case (r_state)
            ST_RX: begin
                if (w_full && (r_commit_ptr == r_rd_ptr)) begin
                    // The open packet alone fills the memory: it can never
                    // complete, so give it up without taking a beat.
                    w_wr_ptr_nxt   = r_commit_ptr;
                    w_drop_nxt     = 1'b1;
                    w_beat_cnt_nxt = BCNT_ZERO;
                    w_err_nxt      = 1'b0;
                    w_state_nxt    = ST_DROP;
                end else begin
                    // Full with committed data waiting: just stall upstream.
                    w_tready = !w_full;
                    if (w_tready && s_axis.tvalid) begin
                        w_wr_en        = 1'b1;
                        w_wr_ptr_nxt   = r_wr_ptr + PTR_ONE;
                        w_beat_cnt_nxt = r_beat_cnt + BCNT_ONE;
                        if (s_axis.tlast) begin
                            if (r_err || w_beat_err) begin
                                w_wr_ptr_nxt = r_commit_ptr;
                                w_drop_nxt   = 1'b1;
                            end else begin
                                w_commit_ptr_nxt = r_wr_ptr + PTR_ONE;
                                w_commit         = 1'b1;
                            end
                            w_beat_cnt_nxt = BCNT_ZERO;
                            w_err_nxt      = 1'b0;
                        end else if (r_beat_cnt == BCNT_LIMIT) begin
                            // MAX_PKT_BEATS reached without tlast: oversize.
                            w_wr_ptr_nxt   = r_commit_ptr;
                            w_drop_nxt     = 1'b1;
                            w_beat_cnt_nxt = BCNT_ZERO;
                            w_err_nxt      = 1'b0;
                            w_state_nxt    = ST_DROP;
                        end else begin
                            w_err_nxt = r_err | w_beat_err;
                        end
                    end else begin
                        w_wr_en = 1'b0;
                    end
                end
            end
            ST_DROP: begin
                // Swallow the rest of the discarded packet up to its tlast.
                w_tready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_state_nxt    = ST_RX;
                    w_beat_cnt_nxt = BCNT_ZERO;
                    w_err_nxt      = 1'b0;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_RX;
            end
        endcase
    end

    // Read side: combinational memory read at rd_ptr
    assign w_rd_entry     = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
    assign w_m_valid      = (r_rd_ptr != r_commit_ptr) && !axis_reset;
    assign w_rd_fire      = w_m_valid && m_axis.tready;
    assign w_rd_last_fire = w_rd_fire && w_rd_entry[DATA_WIDTH + TKEEP_WIDTH];

    assign s_axis.tready = w_tready && !axis_reset;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = w_rd_entry[DATA_WIDTH-1:0];
    assign m_axis.tkeep  = w_rd_entry[DATA_WIDTH +: TKEEP_WIDTH];
    assign m_axis.tlast  = w_rd_entry[DATA_WIDTH + TKEEP_WIDTH];
`ifdef AXIS_PKT_FIFO_TUSER_DROP_EN
    assign m_axis.tuser  = {TUSER_WIDTH{1'b0}};
`else
    assign m_axis.tuser  = w_rd_entry[DATA_WIDTH + TKEEP_WIDTH + 1 +: TUSER_WIDTH];
`endif

    assign drop_pulse = r_drop_pulse;
    assign pkt_count  = r_pkt_count;

    // FSM state register
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_state <= ST_RX;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, packet bookkeeping and drop pulse
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_err        <= w_err_nxt;
            r_drop_pulse <= w_drop_nxt;
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_commit, w_rd_last_fire})
                2'b10:   r_pkt_count <= r_pkt_count + CNT_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - CNT_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    // Beat storage; contents need no reset since only committed entries are read
    always_ff @(posedge axis_aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= w_wr_entry;
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
`timescale 1ns/1ps
// Two FIFO instances share one clock: instance 0 (MAX_PKT_BEATS=8) exercises
// oversize drops, instance 1 (MAX_PKT_BEATS=64 > depth 16) exercises overflow.
module tb_axis_pkt_fifo;
    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int UW    = 1;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH);
    localparam int NCYC  = 3000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done [2];

    task automatic check(input string name, input int inst,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int MAXB = (g == 0) ? 8 : 64;

        logic           rst;
        logic           drop_pulse;
        logic [PW:0]    pkt_count;

        axis_pkt_fifo_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
        axis_pkt_fifo_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

        axis_pkt_fifo #(
            .DATA_WIDTH   (DW),
            .FIFO_DEPTH   (DEPTH),
            .TUSER_WIDTH  (UW),
            .MAX_PKT_BEATS(MAXB)
        ) u_dut (
            .axis_aclk (clk),
            .axis_reset(rst),
            .s_axis    (s_if),
            .m_axis    (m_if),
            .drop_pulse(drop_pulse),
            .pkt_count (pkt_count)
        );

        // reference model state: open packet, committed-but-unread packets
        beat_t cur_q [$];
        beat_t sb_q  [$];
        int    len_q [$];
        int    stored    = 0;
        int    rd_in_pkt = 0;
        int    n_out     = 0;
        bit    cur_err   = 1'b0;
        bit    dropping  = 1'b0;
        bit    exp_drop  = 1'b0;

        // Reference model: predicts handshakes, counts and drops from packet rules
        always @(negedge clk) begin : model
            int    occ;
            bit    full, exp_trdy, exp_mval, new_drop, berr;
            beat_t b;
            occ      = stored + cur_q.size();
            full     = (occ == DEPTH);
            exp_trdy = rst ? 1'b0 : (dropping ? 1'b1 : !full);
            exp_mval = rst ? 1'b0 : (stored != 0);
            check("s_tready",   g, 64'(s_if.tready), 64'(exp_trdy));
            check("m_tvalid",   g, 64'(m_if.tvalid), 64'(exp_mval));
            check("pkt_count",  g, 64'(pkt_count),   64'(len_q.size()));
            check("drop_pulse", g, 64'(drop_pulse),  64'(exp_drop));
            new_drop = 1'b0;
            if (rst) begin
                cur_q.delete(); sb_q.delete(); len_q.delete();
                stored = 0; rd_in_pkt = 0; cur_err = 1'b0; dropping = 1'b0;
            end else begin
                if (!dropping && full && stored == 0) begin
                    cur_q.delete(); cur_err = 1'b0; dropping = 1'b1; new_drop = 1'b1;
                end else if (s_if.tvalid && exp_trdy) begin
                    if (dropping) begin
                        if (s_if.tlast) dropping = 1'b0;
                    end else begin
                        b.data = s_if.tdata;
                        b.keep = s_if.tkeep;
                        b.last = s_if.tlast;
`ifdef AXIS_PKT_FIFO_TUSER_DROP_EN
                        b.user = '0;
                        berr   = s_if.tuser[0];
`else
                        b.user = s_if.tuser;
                        berr   = 1'b0;
`endif
                        cur_q.push_back(b);
                        if (s_if.tlast) begin
                            if (cur_err || berr) begin
                                new_drop = 1'b1;
                            end else begin
                                foreach (cur_q[i]) sb_q.push_back(cur_q[i]);
                                len_q.push_back(cur_q.size());
                                stored += cur_q.size();
                            end
                            cur_q.delete(); cur_err = 1'b0;
                        end else if (cur_q.size() == MAXB) begin
                            cur_q.delete(); cur_err = 1'b0; dropping = 1'b1; new_drop = 1'b1;
                        end else begin
                            cur_err = cur_err | berr;
                        end
                    end
                end
                if (exp_mval && m_if.tready) begin
                    stored--;
                    rd_in_pkt++;
                    if (rd_in_pkt == len_q[0]) begin
                        void'(len_q.pop_front());
                        rd_in_pkt = 0;
                    end
                end
            end
            exp_drop = new_drop;
        end

        // Output monitor: pops the scoreboard on every downstream transfer
        always @(negedge clk) begin : monitor
            beat_t e;
            if (!rst && m_if.tvalid && m_if.tready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat inst%0d: got data %0h, expected no beat at %0t",
                             g, m_if.tdata, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("tdata", g, 64'(m_if.tdata), 64'(e.data));
                    check("tkeep", g, 64'(m_if.tkeep), 64'(e.keep));
                    check("tlast", g, 64'(m_if.tlast), 64'(e.last));
                    check("tuser", g, 64'(m_if.tuser), 64'(e.user));
                end
            end
        end

        // Random packet stimulus, downstream back-pressure phases and resets
        initial begin : stim
            int len, idx, phase;
            bit fired, have_pkt;
            s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
            s_if.tlast  = 1'b0; s_if.tuser = '0;
            m_if.tready = 1'b0;
            rst = 1'b1;
            have_pkt = 1'b0; idx = 0; len = 0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(negedge clk);
                fired = s_if.tvalid && s_if.tready;
                @(posedge clk);
                #1;
                rst = (cyc >= 1200 && cyc < 1202) ||
                      (cyc >= 2300 + g * 37 && cyc < 2302 + g * 37);
                if (fired) begin
                    if (s_if.tlast) have_pkt = 1'b0;
                    else            idx++;
                end
                if (!have_pkt) begin
                    if (g == 0)                          len = $urandom_range(1, 12);
                    else if ($urandom_range(0, 5) == 0)  len = $urandom_range(14, 20);
                    else                                 len = $urandom_range(1, 10);
                    idx = 0;
                    have_pkt = 1'b1;
                end
                if (!(s_if.tvalid && !fired)) begin
                    if ($urandom_range(0, 3) != 0) begin
                        s_if.tvalid = 1'b1;
                        s_if.tdata  = $urandom;
                        s_if.tkeep  = KW'($urandom);
                        s_if.tlast  = (idx == len - 1);
                        s_if.tuser  = ($urandom_range(0, 7) == 0) ? UW'(1) : UW'(0);
                    end else begin
                        s_if.tvalid = 1'b0;
                    end
                end
                phase = (cyc / 250) % 3;
                if (phase == 0)      m_if.tready = 1'b1;
                else if (phase == 1) m_if.tready = 1'($urandom_range(0, 1));
                else                 m_if.tready = ($urandom_range(0, 9) == 0);
            end
            s_if.tvalid = 1'b0;
            m_if.tready = 1'b1;
            repeat (150) @(posedge clk);
            #1;
            check("drained", g, 64'(sb_q.size()), 64'(0));
            check("outputs_seen", g, 64'(n_out > 0), 64'(1));
            done[g] = 1'b1;
        end
    end

    // Wait for both instances (bounded), then report
    initial begin
        for (int c = 0; c < NCYC + 1000; c++) begin
            @(posedge clk);
            if (done[0] && done[1]) break;
        end
        if (!(done[0] && done[1])) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got done=%0b%0b, expected 11", done[1], done[0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
Single-clock store-and-forward packet FIFO on AXI Stream. It sits directly downstream of the async CDC FIFO in the m_axis clock domain.
A packet becomes visible on the master side only after its tlast beat is accepted. Errored, oversized or overflowing packets are discarded whole, so downstream never sees a partial frame.

Parameters:
DATA_WIDTH, 32, tdata width in bits (multiple of 8); TKEEP_WIDTH = DATA_WIDTH/8 (localparam)
FIFO_DEPTH, 64, storage depth in beats (power of 2, >= 4); PTR_WIDTH = $clog2(FIFO_DEPTH) (localparam)
TUSER_WIDTH, 1, tuser width; bit 0 is the frame-error flag
MAX_PKT_BEATS, 64, maximum legal packet length in beats (1..65535)

Ports:
axis_aclk  input  1  clock
axis_reset  input  1  synchronous reset, active high
s_axis_tvalid  input  1  upstream beat valid
s_axis_tdata  input  DATA_WIDTH  upstream data
s_axis_tkeep  input  TKEEP_WIDTH  upstream byte enables
s_axis_tlast  input  1  last beat of packet
s_axis_tuser  input  TUSER_WIDTH  sideband; bit 0 = frame error
s_axis_tready  output  1  accept beat
m_axis_tvalid  output  1  downstream beat valid
m_axis_tdata  output  DATA_WIDTH  downstream data
m_axis_tkeep  output  TKEEP_WIDTH  downstream byte enables
m_axis_tlast  output  1  last beat of packet
m_axis_tuser  output  TUSER_WIDTH  downstream sideband
m_axis_tready  input  1  downstream accept
drop_pulse  output  1  one-cycle pulse per discarded packet
pkt_count  output  PTR_WIDTH+1  number of complete packets stored

Behaviour:
- Single clock. Reset is synchronous and active-high: axis_aclk, axis_reset.
- Storage: memory of DATA_WIDTH+TKEEP_WIDTH+1 bits per beat (+TUSER_WIDTH when the tuser-drop macro is undefined); combinational read.
- Pointers, all binary, PTR_WIDTH+1 bits, wrapping naturally:
  - wr_ptr: speculative write pointer
  - commit_ptr: end of the last good packet
  - rd_ptr: read pointer
- full = (wr_ptr - rd_ptr) == FIFO_DEPTH.
- FSM states:
  - RX (reset state): s_axis_tready = !full. On accept: write mem[wr_ptr], wr_ptr++, beat_cnt++, err |= tuser[0].
  - DROP: s_axis_tready = 1; beats are discarded. tlast accepted -> RX, beat_cnt=0, err=0.
- Commit: tlast accepted in RX with err==0 and this beat's tuser[0]==0 -> commit_ptr <= wr_ptr+1 (next cycle), pkt_count++, beat_cnt=0.
- Error drop: tlast accepted with error (sticky err or current tuser[0]) -> wr_ptr <= commit_ptr, drop_pulse=1 next cycle, stay RX.
- Oversize: accepted beat is number MAX_PKT_BEATS and tlast=0 -> wr_ptr <= commit_ptr, drop_pulse, -> DROP.
- Overflow: in RX, full && commit_ptr==rd_ptr (the packet alone fills the FIFO) -> wr_ptr <= commit_ptr, drop_pulse, -> DROP, without accepting a beat that cycle.
- Full with committed data waiting: hold tready=0; no drop.
- m_axis_tvalid = (rd_ptr != commit_ptr). Outputs are mem[rd_ptr] fields. rd_ptr++ on tvalid&&tready.
- pkt_count-- when the tlast beat is read.
- Latency: a single-beat packet accepted at cycle N is valid on m_axis at N+1.
- Simultaneous commit and last-beat read: pkt_count unchanged. Simultaneous write and read always permitted.
- Reset (any time, including mid-packet or mid-read): all pointers=0, state RX, beat_cnt=0, err=0, drop_pulse=0, pkt_count=0.
  - While axis_reset=1: s_axis_tready=0, m_axis_tvalid=0.
  - A partial packet is lost. Upstream remainder beats are treated as a new packet.
- m_axis outputs are stable while tvalid && !tready (AXI rule).

Optional Feature:
Macro AXIS_PKT_FIFO_TUSER_DROP_EN.
- Defined: tuser[0] errors drop packets as described; tuser is not stored; m_axis_tuser = 0.
- Undefined: tuser is not an error source (err never set). tuser is stored per beat and forwarded on m_axis_tuser. Only oversize/overflow drops occur.

Test Plan:
- Reset, then 4-beat packet tdata 1..4, tlast on beat 4, m_axis_tready=1 -> m_axis_tvalid rises the cycle after beat 4, beats 1..4 out in order, pkt_count 1->0.
- (macro defined) 3-beat packet with tuser[0]=1 on beat 2, then good 2-beat packet -> drop_pulse once, only the 2-beat packet appears, pkt_count max 1.
- MAX_PKT_BEATS=8, 12-beat packet -> drop_pulse after beat 8, tready stays 1 through beat 12, no output; the next packet passes intact.
- FIFO_DEPTH=16, m_axis_tready=0, two committed 6-beat packets plus a third -> tready=0 after 4 beats of the third, no drop. Release tready -> all 18 beats out correctly.
- FIFO_DEPTH=16, 20-beat packet into empty FIFO -> overflow drop_pulse at 16 beats, remaining 4 beats absorbed, m_axis_tvalid never 1.
- Assert axis_reset mid-read of a 5-beat packet -> tvalid=0 the cycle after reset, pkt_count=0, the following 1-beat packet is output with 1-cycle latency.
